// File: rtl/cmp_sort_ctrl.sv
// Four-element ascending bubble sort with early exit, time-sharing one external
// combinational comparator: one compare (and optional swap) per clock.
module cmp_sort_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]   cmp_a,
  output logic [WIDTH-1:0]   cmp_b,
  input  logic               cmp_gt,
  input  logic               cmp_lt,
  output logic               busy,
  output logic               done,
  output logic [4*WIDTH-1:0] out_data,
  output logic [2:0]         swaps,
  output logic               err
);

  localparam int NUM_ELEM = 4;

  typedef enum logic {IDLE, CMP} state_t;
  typedef logic [NUM_ELEM-1:0][WIDTH-1:0] vec_t;

  state_t     r_state, w_state;
  vec_t       r_elem,  w_elem;
  vec_t       r_out,   w_out;
  logic [1:0] r_pass,  w_pass;
  logic [1:0] r_idx,   w_idx;
  logic       r_ps,    w_ps;
  logic       r_done,  w_done;
  logic       r_err,   w_err;
  logic [2:0] r_swaps, w_swaps;

  logic [1:0] w_idx1;
  logic       w_last;
  logic       w_swap_seen;
  logic       w_busy;

  assign w_busy      = (r_state == CMP);
  assign w_idx1      = r_idx + 2'd1;
  // pass p walks idx 0..2-p; the largest remaining value settles at the top
  assign w_last      = (r_idx == (2'd2 - r_pass));
  assign w_swap_seen = r_ps | cmp_gt;

  assign cmp_a    = w_busy ? r_elem[r_idx]  : '0;
  assign cmp_b    = w_busy ? r_elem[w_idx1] : '0;
  assign busy     = w_busy;
  assign done     = r_done;
  assign out_data = r_out;
  assign swaps    = r_swaps;
  assign err      = r_err;

  always_comb begin
    w_state = r_state;
    w_elem  = r_elem;
    w_out   = r_out;
    w_pass  = r_pass;
    w_idx   = r_idx;
    w_ps    = r_ps;
    w_done  = 1'b0;
    w_err   = r_err;
    w_swaps = r_swaps;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_elem  = in_data;
          w_swaps = '0;
          w_err   = 1'b0;
          w_ps    = 1'b0;
          w_pass  = '0;
          w_idx   = '0;
          w_state = CMP;
        end
      end
      CMP: begin
        // only strict a>b swaps, so equal keys keep their order
        if (cmp_gt) begin
          w_elem[r_idx]  = r_elem[w_idx1];
          w_elem[w_idx1] = r_elem[r_idx];
          w_swaps        = r_swaps + 3'd1;
        end
        if (cmp_gt && cmp_lt) w_err = 1'b1;
        if (w_last) begin
          if (!w_swap_seen || r_pass == 2'd2) begin
            w_out   = w_elem;
            w_done  = 1'b1;
            w_state = IDLE;
            w_idx   = '0;
            w_pass  = '0;
            w_ps    = 1'b0;
          end else begin
            w_pass = r_pass + 2'd1;
            w_idx  = '0;
            w_ps   = 1'b0;
          end
        end else begin
          w_idx = w_idx1;
          w_ps  = w_swap_seen;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_elem  <= '0;
      r_out   <= '0;
      r_pass  <= '0;
      r_idx   <= '0;
      r_ps    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_swaps <= '0;
    end else begin
      r_state <= w_state;
      r_elem  <= w_elem;
      r_out   <= w_out;
      r_pass  <= w_pass;
      r_idx   <= w_idx;
      r_ps    <= w_ps;
      r_done  <= w_done;
      r_err   <= w_err;
      r_swaps <= w_swaps;
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Bench for cmp_sort_ctrl: behavioural comparator, scoreboard of expected
// results pushed at start and popped when done pulses.
module tb_cmp_sort_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4*W-1:0] in_data = '0;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_gt, cmp_lt;
  logic         busy, done, err;
  logic [4*W-1:0] out_data;
  logic [2:0]   swaps;
  logic         force_both = 1'b0;

  typedef struct {
    logic [4*W-1:0] out;
    logic [2:0]     sw;
    int             ncmp;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] pair_q[$];
  int total = 0;
  int bad   = 0;

  assign cmp_gt = force_both | (cmp_a > cmp_b);
  assign cmp_lt = force_both | (cmp_a < cmp_b);

  always #5 clk = ~clk;

  cmp_sort_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .out_data(out_data), .swaps(swaps), .err(err)
  );

  function automatic logic [4*W-1:0] pk(input logic [W-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Starts a sort (at the current negedge if b2b, else the next one) and
  // follows it to done; inject re-pulses start mid-sort, force_at forces
  // gt=lt=1 on that compare number.
  task automatic do_sort(input logic [4*W-1:0] v, input logic [4*W-1:0] eo,
                         input logic [2:0] es, input int en, input bit b2b,
                         input bit inject, input int force_at);
    exp_t e;
    int nb;
    bit seen;
    logic [7:0] p;
    if (!b2b) @(negedge clk);
    in_data = v;
    start   = 1'b1;
    e.out = eo; e.sw = es; e.ncmp = en;
    sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) begin
        nb++;
        if (pair_q.size() > 0) begin
          p = pair_q.pop_front();
          total++;
          if ({cmp_a, cmp_b} !== p) begin
            bad++;
            $display("FAIL operands cmp%0d got=%0d,%0d want=%0d,%0d", nb, cmp_a, cmp_b, p[7:4], p[3:0]);
          end
        end
        force_both = (nb == force_at);
        if (inject && nb == 2) begin
          start   = 1'b1;
          in_data = pk(4'd0, 4'd0, 4'd0, 4'd0);
        end else start = 1'b0;
      end
    end
    force_both = 1'b0;
    start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout got=no_done want=done");
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      total++;
      if (out_data !== e.out) begin
        bad++;
        $display("FAIL out_data got=%h want=%h", out_data, e.out);
      end
      total++;
      if (swaps !== e.sw) begin
        bad++;
        $display("FAIL swaps got=%0d want=%0d", swaps, e.sw);
      end
      total++;
      if (nb !== e.ncmp) begin
        bad++;
        $display("FAIL compares got=%0d want=%0d", nb, e.ncmp);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_at_done got=%b want=0", busy);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy, done, err, swaps, out_data, cmp_a, cmp_b} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b%b%b %0d %h %0d %0d want=all_zero", busy, done, err, swaps, out_data, cmp_a, cmp_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_sort();
    pair_q = '{8'h93, 8'h97, 8'h91, 8'h37, 8'h71, 8'h31};
    do_sort(pk(9, 3, 7, 1), pk(1, 3, 7, 9), 3'd5, 6, 1'b0, 1'b0, 0);
    total++;
    if (pair_q.size() != 0) begin
      bad++;
      $display("FAIL operand_pairs_left got=%0d want=0", pair_q.size());
    end
    pair_q.delete();
  endtask

  task automatic test_sorted();
    do_sort(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 3'd0, 3, 1'b0, 1'b0, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || out_data !== pk(1, 2, 3, 4)) begin
      bad++;
      $display("FAIL done_pulse_hold got=%b %h want=0 %h", done, out_data, pk(1, 2, 3, 4));
    end
  endtask

  task automatic test_back_to_back();
    do_sort(pk(15, 10, 5, 0), pk(0, 5, 10, 15), 3'd6, 6, 1'b0, 1'b0, 0);
    do_sort(pk(5, 5, 2, 5), pk(2, 5, 5, 5), 3'd2, 6, 1'b1, 1'b0, 0);
  endtask

  task automatic test_start_while_busy();
    do_sort(pk(9, 3, 7, 1), pk(1, 3, 7, 9), 3'd5, 6, 1'b0, 1'b1, 0);
  endtask

  task automatic test_err();
    do_sort(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 3'd2, 6, 1'b0, 1'b0, 1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b want=1", err);
    end
    repeat (3) @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b want=1", err);
    end
    do_sort(pk(1, 2, 3, 4), pk(1, 2, 3, 4), 3'd0, 3, 1'b0, 1'b0, 0);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared got=%b want=0", err);
    end
  endtask

  task automatic test_reset_midsort();
    @(negedge clk);
    in_data = pk(9, 3, 7, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, err, swaps, out_data, cmp_a, cmp_b} !== '0) begin
      bad++;
      $display("FAIL reset_midsort got=%b%b%b %0d %h %0d %0d want=all_zero", busy, done, err, swaps, out_data, cmp_a, cmp_b);
    end
    @(negedge clk);
    rst = 1'b0;
    do_sort(pk(4, 3, 2, 1), pk(1, 2, 3, 4), 3'd6, 6, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_full_sort();
    test_sorted();
    test_back_to_back();
    test_start_while_busy();
    test_err();
    test_reset_midsort();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
